// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM encoding and the combinational instruction decode
// for alu_ctrl_mdu. Define ALU_CTRL_DIV_EN to make div/divu legal MDU ops.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    localparam logic [1:0] OP_LS    = 2'b00;
    localparam logic [1:0] OP_BEQ   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_ORI   = 2'b11;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [1:0] HILO_ALU = 2'b00;
    localparam logic [1:0] HILO_HI  = 2'b01;
    localparam logic [1:0] HILO_LO  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    typedef struct packed {
        logic [3:0] code;
        logic [1:0] hilo_sel;
        logic       illegal;
        logic       mdu;
        logic       hilo_rd;
    } dec_t;

    // illegal is raw here; the caller qualifies it with valid.
    function automatic dec_t decode(input logic [1:0] op, input logic [5:0] f);
        dec_t d;
        d.code     = ALU_AND;
        d.hilo_sel = HILO_ALU;
        d.illegal  = 1'b0;
        d.mdu      = 1'b0;
        d.hilo_rd  = 1'b0;
        case (op)
            OP_LS:  d.code = ALU_ADD;
            OP_BEQ: d.code = ALU_SUB;
            OP_ORI: d.code = ALU_OR;
            default: begin
                case (f)
                    F_ADD:  d.code = ALU_ADD;
                    F_SUB:  d.code = ALU_SUB;
                    F_AND:  d.code = ALU_AND;
                    F_OR:   d.code = ALU_OR;
                    F_SLT:  d.code = ALU_SLT;
                    F_NOR:  d.code = ALU_NOR;
                    F_SLTU: d.code = ALU_SLTU;
                    F_MFHI: begin
                        d.code     = ALU_PASS;
                        d.hilo_sel = HILO_HI;
                        d.hilo_rd  = 1'b1;
                    end
                    F_MFLO: begin
                        d.code     = ALU_PASS;
                        d.hilo_sel = HILO_LO;
                        d.hilo_rd  = 1'b1;
                    end
                    F_MULT, F_MULTU: d.mdu = 1'b1;
`ifdef ALU_CTRL_DIV_EN
                    F_DIV, F_DIVU:   d.mdu = 1'b1;
`endif
                    default: d.illegal = 1'b1;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_ctrl_mdu_iter.sv
// Shift-add multiply / restoring divide iteration datapath with its step counter.
// Operands arrive as magnitudes; sign handling lives in the parent.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             last_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;
`ifdef ALU_CTRL_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   rem, diff;
`endif

    // Multiply: {hi,lo} holds partial product over the shifting multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
`ifdef ALU_CTRL_DIV_EN
        rem   = {hi_q, lo_q[WIDTH-1]};
        diff  = rem - {1'b0, opnd_q};
`endif
        if (load_i) begin
            hi_d  = '0;
            lo_d  = div_i ? a_i : b_i;
            cnt_d = CNT_W'(WIDTH);
        end else if (step_i) begin
            cnt_d        = cnt_q - CNT_W'(1);
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
`ifdef ALU_CTRL_DIV_EN
            if (div_q) begin
                if (diff[WIDTH]) begin
                    hi_d = rem[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end else begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
`ifdef ALU_CTRL_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
            if (load_i) begin
                opnd_q <= div_i ? b_i : a_i;
`ifdef ALU_CTRL_DIV_EN
                div_q  <= div_i;
`endif
            end
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// Define ALU_CTRL_DIV_EN to build the divide path; otherwise div/divu are illegal.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [1:0]        op_alu,
    input  logic [5:0]        funct,
    input  logic [WIDTH-1:0]  opa,
    input  logic [WIDTH-1:0]  opb,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [1:0]        hilo_sel,
    output logic              illegal,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic              divz,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);
    dec_t               dec;
    mdu_state_e         state_q, state_d;
    logic               accept, req_signed, req_div, sa, sb, step, it_last, neg_q;
    logic [WIDTH-1:0]   a_mag, b_mag, it_hi, it_lo, hi_q, lo_q, hi_d, lo_d;
    logic [2*WIDTH-1:0] prod;
`ifdef ALU_CTRL_DIV_EN
    logic               div_q, dz_q, rneg_q;
    logic [WIDTH-1:0]   opa_q;
`endif

    assign dec      = decode(op_alu, funct);
    assign alu_ctrl = CTRL_W'(dec.code);
    assign hilo_sel = dec.hilo_sel;
    assign illegal  = valid & dec.illegal;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // dec.mdu is only ever set for R-type, so op_alu is already qualified.
    assign accept     = valid & dec.mdu & (state_q == ST_IDLE);
    assign req_signed = ~funct[0];
`ifdef ALU_CTRL_DIV_EN
    assign req_div    = funct[1];
`else
    assign req_div    = 1'b0;
`endif
    assign sa    = req_signed & opa[WIDTH-1];
    assign sb    = req_signed & opb[WIDTH-1];
    assign a_mag = sa ? -opa : opa;
    assign b_mag = sb ? -opb : opb;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (accept),
        .div_i  (req_div),
        .step_i (step),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .hi_o   (it_hi),
        .lo_o   (it_lo),
        .last_o (it_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) begin
`ifdef ALU_CTRL_DIV_EN
                if (req_div) state_d = (opb == '0) ? ST_FIX : ST_DIV;
                else         state_d = ST_MUL;
`else
                state_d = ST_MUL;
`endif
            end
            ST_MUL, ST_DIV: if (it_last) state_d = ST_FIX;
            ST_FIX:         state_d = ST_DONE;
            ST_DONE:        state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        step = 1'b0;
        unique case (state_q)
            ST_MUL, ST_DIV: begin
                busy = 1'b1;
                step = 1'b1;
            end
            ST_FIX:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
        // Anything touching HI/LO waits until the unit is back in IDLE.
        stall = valid & (dec.mdu | dec.hilo_rd) & (busy | (state_q != ST_IDLE));
    end

`ifdef ALU_CTRL_DIV_EN
    assign divz = done & dz_q;
`else
    assign divz = 1'b0;
`endif

    // Sign restore: product/quotient take sa^sb, the remainder takes the dividend sign.
    always_comb begin
        prod = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
`ifdef ALU_CTRL_DIV_EN
        if (div_q) begin
            if (dz_q) begin
                hi_d = opa_q;
                lo_d = '1;
            end else begin
                hi_d = rneg_q ? -it_hi : it_hi;
                lo_d = neg_q  ? -it_lo : it_lo;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            neg_q  <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
            div_q  <= 1'b0;
            dz_q   <= 1'b0;
            rneg_q <= 1'b0;
            opa_q  <= '0;
`endif
        end else begin
            if (accept) begin
                neg_q  <= sa ^ sb;
`ifdef ALU_CTRL_DIV_EN
                div_q  <= req_div;
                dz_q   <= req_div & (opb == '0);
                rneg_q <= sa;
                opa_q  <= opa;
`endif
            end
            if (state_q == ST_FIX) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
        end
    end

endmodule
